// File: rtl/ping_pong_counter_gen.sv
// ping_pong_counter_gen: up/down counter confined to an unsigned window
// [min, max]. In bounce mode it turns around at the window edges. In wrap
// mode it jumps to the opposite edge when a step would leave the window.
// Optional feature: define PPC_BOUNCE_CNT_EN to add a saturating 16-bit
// bounce_cnt output that counts the cycles in which bounce is set.
module ping_pong_counter_gen #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             flip,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             load_dir,
    input  logic             mode,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] out,
    output logic             direction,
`ifdef PPC_BOUNCE_CNT_EN
    output logic             bounce,
    output logic [15:0]      bounce_cnt
`else
    output logic             bounce
`endif
);

    // Sums are one bit wider than the count so that they never wrap.
    // "out - step < min" is tested as "out < min + step" to avoid a borrow.
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_limit;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] dn_val;
    logic             up_over;
    logic             dn_under;

    assign up_sum   = {1'b0, out} + {1'b0, step};
    assign dn_limit = {1'b0, min} + {1'b0, step};
    assign up_over  = up_sum > {1'b0, max};
    assign dn_under = {1'b0, out} < dn_limit;
    assign up_val   = up_sum[WIDTH-1:0];
    assign dn_val   = out - step;   // only used when out >= min + step, so it cannot borrow

    logic [WIDTH-1:0] out_next;
    logic             direction_next;
    logic             bounce_next;
    logic             eff_dir;

    // Next-state selection, in priority order: load, hold, re-entry, count
    always_comb begin
        out_next       = out;
        direction_next = direction;
        bounce_next    = 1'b0;
        eff_dir        = direction ^ flip;
        if (load) begin
            out_next       = load_val;
            direction_next = load_dir;
        end else if (!enable || (min >= max) || (step == '0)) begin
            // hold: defaults already keep out and direction
        end else if ((out < min) || (out > max)) begin
            out_next       = min;
            direction_next = 1'b1;
        end else if (!mode) begin
            // bounce mode: turn around at an edge, then step and clamp
            if (eff_dir && (out == max)) begin
                eff_dir     = 1'b0;
                bounce_next = 1'b1;
            end else if (!eff_dir && (out == min)) begin
                eff_dir     = 1'b1;
                bounce_next = 1'b1;
            end
            if (eff_dir) begin
                out_next = up_over ? max : up_val;
            end else begin
                out_next = dn_under ? min : dn_val;
            end
            direction_next = eff_dir;
        end else begin
            // wrap mode: leaving the window jumps to the opposite edge
            if (eff_dir) begin
                out_next    = up_over ? min : up_val;
                bounce_next = up_over;
            end else begin
                out_next    = dn_under ? max : dn_val;
                bounce_next = dn_under;
            end
            direction_next = eff_dir;
        end
    end

    // Register the count, direction and bounce pulse; reset starts at min going up
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= min;
            direction <= 1'b1;
            bounce    <= 1'b0;
        end else begin
            out       <= out_next;
            direction <= direction_next;
            bounce    <= bounce_next;
        end
    end

`ifdef PPC_BOUNCE_CNT_EN
    // Saturating count of bounce events, cleared by reset and by load
    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            bounce_cnt <= 16'h0000;
        end else if (bounce_next && (bounce_cnt != 16'hFFFF)) begin
            bounce_cnt <= bounce_cnt + 16'h0001;
        end
    end
`endif

endmodule
